// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: 2-bit branch counter encodings, counter reset
// value and the default PC width.
package pipeline_pkg;

  localparam int unsigned PC_W_DEF = 8;

  // 2-bit saturating branch counter; the MSB is the taken prediction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam bht_cnt_e BHT_RESET = WNT;

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters.
// Ports:
//   clk, reset    clock, asynchronous active-low reset (all entries -> WNT)
//   rd_idx        lookup index
//   rd_taken_c    combinational prediction (counter MSB), no bypass of a same-cycle update
//   upd_en        apply an update at the next rising edge
//   upd_idx       index to update
//   upd_taken     resolved outcome; counter steps one toward it, saturating
module bht_2bit
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken_c,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt_q [DEPTH];
  logic [1:0] cur_cnt;
  logic [1:0] nxt_cnt;

  assign rd_taken_c = cnt_q[rd_idx][1];

  // Saturating step toward the resolved outcome
  always_comb begin
    cur_cnt = cnt_q[upd_idx];
    nxt_cnt = cur_cnt;
    if (upd_taken) begin
      if (cur_cnt != ST) nxt_cnt = cur_cnt + 2'd1;
    end else begin
      if (cur_cnt != SNT) nxt_cnt = cur_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) cnt_q[i] <= BHT_RESET;
    end else if (upd_en) begin
      cnt_q[upd_idx] <= nxt_cnt;
    end
  end

endmodule

// File: rtl/ex_branch_predict_unit.sv
// EX-stage branch prediction unit: BHT lookup for fetch, mispredict detection,
// redirect generation, post-flush bubble suppression and resolve statistics.
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   pc_F / predict_F                 fetch lookup and its combinational prediction
//   branch_EX, pc_EX, pcBranch_EX,   EX-stage branch, its PC, target and
//   pcPlus2_EX                       fall-through address
//   prediction_EX, taken_EX          prediction carried along and resolved outcome
//   stall_EX                         EX held: no state change, no flush
//   flush_EX / redirect_pc           combinational mispredict flush and corrected PC
//   branch_cnt, mispredict_cnt       saturating resolve / mispredict counters
module ex_branch_predict_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned STAT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   pc_F,
  output logic              predict_F,
  input  logic              branch_EX,
  input  logic [PC_W-1:0]   pc_EX,
  input  logic [PC_W-1:0]   pcBranch_EX,
  input  logic [PC_W-1:0]   pcPlus2_EX,
  input  logic              prediction_EX,
  input  logic              taken_EX,
  input  logic              stall_EX,
  output logic              flush_EX,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispredict_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic flush_q;
  logic resolve_c;
  logic mispredict_c;
  logic unused_pc_bits;

  // Upper PC bits do not take part in indexing
  assign unused_pc_bits = ^{pc_F[PC_W-1:IDX_W], pc_EX[PC_W-1:IDX_W]};

  // A branch resolves only when EX advances and is not the bubble behind a flush;
  // gating by reset keeps flush_EX low while the block is held in reset
  assign resolve_c    = reset & branch_EX & ~stall_EX & ~flush_q;
  assign mispredict_c = resolve_c & (prediction_EX != taken_EX);
  assign flush_EX     = mispredict_c;
  assign redirect_pc  = flush_EX ? (taken_EX ? pcBranch_EX : pcPlus2_EX) : '0;

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (pc_F[IDX_W-1:0]),
    .rd_taken_c (predict_F),
    .upd_en     (resolve_c),
    .upd_idx    (pc_EX[IDX_W-1:0]),
    .upd_taken  (taken_EX)
  );

  // Remember a flush so the following bubble cycle cannot resolve
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flush_q <= 1'b0;
    else if (!stall_EX) flush_q <= flush_EX;
  end

  // Saturating statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (resolve_c && (branch_cnt != '1)) branch_cnt <= branch_cnt + STAT_W'(1);
      if (mispredict_c && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_branch_predict_unit.sv
// Directed self-checking bench for ex_branch_predict_unit.
module tb_ex_branch_predict_unit;

  localparam int unsigned PC_W   = 8;
  localparam int unsigned STAT_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC_W-1:0]   pc_F;
  logic              predict_F;
  logic              branch_EX;
  logic [PC_W-1:0]   pc_EX;
  logic [PC_W-1:0]   pcBranch_EX;
  logic [PC_W-1:0]   pcPlus2_EX;
  logic              prediction_EX;
  logic              taken_EX;
  logic              stall_EX;
  logic              flush_EX;
  logic [PC_W-1:0]   redirect_pc;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispredict_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ex_branch_predict_unit #(
    .PC_W      (PC_W),
    .BHT_DEPTH (64),
    .STAT_W    (STAT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_F           (pc_F),
    .predict_F      (predict_F),
    .branch_EX      (branch_EX),
    .pc_EX          (pc_EX),
    .pcBranch_EX    (pcBranch_EX),
    .pcPlus2_EX     (pcPlus2_EX),
    .prediction_EX  (prediction_EX),
    .taken_EX       (taken_EX),
    .stall_EX       (stall_EX),
    .flush_EX       (flush_EX),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an EX-stage branch (fall-through = pc+2)
  task automatic drive_br(input logic [PC_W-1:0] pc, input logic pred, input logic tk,
                          input logic [PC_W-1:0] tgt);
    branch_EX     = 1'b1;
    pc_EX         = pc;
    pcBranch_EX   = tgt;
    pcPlus2_EX    = pc + PC_W'(2);
    prediction_EX = pred;
    taken_EX      = tk;
  endtask

  task automatic idle();
    branch_EX = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int bc, input int mc);
    check({tag, "_branch_cnt"}, 32'(branch_cnt), 32'(bc));
    check({tag, "_mispredict_cnt"}, 32'(mispredict_cnt), 32'(mc));
  endtask

  initial begin
    reset = 1'b0; pc_F = '0; branch_EX = 1'b0; pc_EX = '0; pcBranch_EX = '0;
    pcPlus2_EX = '0; prediction_EX = 1'b0; taken_EX = 1'b0; stall_EX = 1'b0;
    step(); step();

    // Reset state
    pc_F = 8'h10; #2;
    check("rst_predict", 32'(predict_F), 0);
    check("rst_flush", 32'(flush_EX), 0);
    check("rst_redirect", 32'(redirect_pc), 0);
    check_counts("rst", 0, 0);
    reset = 1'b1;
    step();

    // First mispredict: taken to 0x40, counter 01 -> 10
    drive_br(8'h10, 1'b0, 1'b1, 8'h40); #2;
    check("mp1_flush", 32'(flush_EX), 1);
    check("mp1_redirect", 32'(redirect_pc), 32'h40);
    step();
    idle(); #2;
    check("mp1_predict", 32'(predict_F), 1);
    check("mp1_bubble_flush", 32'(flush_EX), 0);
    check_counts("mp1", 1, 1);
    step();

    // Three correctly-predicted taken: 10 -> 11 -> 11 -> 11
    for (int k = 0; k < 3; k++) begin
      drive_br(8'h10, 1'b1, 1'b1, 8'h40); #2;
      check("sat_flush", 32'(flush_EX), 0);
      step();
      idle(); #2;
      check("sat_predict", 32'(predict_F), 1);
    end
    check_counts("sat", 4, 1);

    // Not-taken with predicted taken: mispredict to fall-through, 11 -> 10
    drive_br(8'h10, 1'b1, 1'b0, 8'h40); #2;
    check("nt1_flush", 32'(flush_EX), 1);
    check("nt1_redirect", 32'(redirect_pc), 32'h12);
    step();
    idle(); #2;
    check("nt1_predict", 32'(predict_F), 1);
    step();
    // Second not-taken: 10 -> 01 proves the previous state was 10
    drive_br(8'h10, 1'b1, 1'b0, 8'h40); #2;
    check("nt2_flush", 32'(flush_EX), 1);
    step();
    idle(); #2;
    check("nt2_predict", 32'(predict_F), 0);
    check_counts("nt2", 6, 3);
    step();

    // Mispredict then a branch in the bubble cycle: bubble must not resolve
    pc_F = 8'h20;
    drive_br(8'h20, 1'b1, 1'b0, 8'h60); #2;
    check("bub_flush1", 32'(flush_EX), 1);
    check("bub_redirect", 32'(redirect_pc), 32'h22);
    step();
    drive_br(8'h20, 1'b0, 1'b1, 8'h60); #2;
    check("bub_flush2", 32'(flush_EX), 0);
    check("bub_redirect2", 32'(redirect_pc), 0);
    step();
    idle(); #2;
    check("bub_predict", 32'(predict_F), 0);
    check_counts("bub", 7, 4);
    step();

    // Stall held three cycles with a mispredicting branch present
    pc_F = 8'h30;
    stall_EX = 1'b1;
    drive_br(8'h30, 1'b0, 1'b1, 8'h70);
    for (int k = 0; k < 3; k++) begin
      #2;
      check("stall_flush", 32'(flush_EX), 0);
      check_counts("stall", 7, 4);
      step();
    end
    check("stall_predict", 32'(predict_F), 0);
    stall_EX = 1'b0; #2;
    check("unstall_flush", 32'(flush_EX), 1);
    check("unstall_redirect", 32'(redirect_pc), 32'h70);
    step();
    idle(); #2;
    check("unstall_bubble_flush", 32'(flush_EX), 0);
    check("unstall_predict", 32'(predict_F), 1);
    check_counts("unstall", 8, 5);
    step();

    // Reset pulsed mid-sequence with a branch in flight
    drive_br(8'h30, 1'b1, 1'b1, 8'h70);
    reset = 1'b0; #2;
    check("mrst_flush", 32'(flush_EX), 0);
    check("mrst_predict30", 32'(predict_F), 0);
    check_counts("mrst", 0, 0);
    step();
    idle();
    pc_F = 8'h10; #1;
    check("mrst_predict10", 32'(predict_F), 0);
    pc_F = 8'h30; #1;
    check("mrst_predict30b", 32'(predict_F), 0);
    reset = 1'b1;
    step();

    // First resolves after release see an all-01 table
    drive_br(8'h30, 1'b0, 1'b0, 8'h70); #2;
    check("post_nt_flush", 32'(flush_EX), 0);
    step();
    idle(); #2;
    check("post_nt_predict", 32'(predict_F), 0);
    drive_br(8'h10, 1'b0, 1'b1, 8'h40); #2;
    check("post_t_flush", 32'(flush_EX), 1);
    step();
    idle(); pc_F = 8'h10; #2;
    check("post_t_predict", 32'(predict_F), 1);
    check_counts("post", 2, 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_branch_predict_unit.md
EX_BRANCH_PREDICT_UNIT -- requirements
Module: ex_branch_predict_unit

Interface
REQ-001 The block SHALL have these parameters: PC_W, default 8, PC width; BHT_DEPTH, default 64, number of 2-bit counters; STAT_W, default 16, width of the statistics counters.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port pc_F, input, PC_W bits: fetch-stage PC to look up.
REQ-005 The block SHALL have the port predict_F, output, 1 bit: taken prediction for pc_F.
REQ-006 The block SHALL have the port branch_EX, input, 1 bit: the EX-stage instruction is a branch.
REQ-007 The block SHALL have the port pc_EX, input, PC_W bits: PC of the EX-stage branch.
REQ-008 The block SHALL have the port pcBranch_EX, input, PC_W bits: branch target of the EX-stage branch.
REQ-009 The block SHALL have the port pcPlus2_EX, input, PC_W bits: fall-through address of the EX-stage branch.
REQ-010 The block SHALL have the port prediction_EX, input, 1 bit: the prediction that travelled with the branch.
REQ-011 The block SHALL have the port taken_EX, input, 1 bit: the resolved branch outcome from the ALU.
REQ-012 The block SHALL have the port stall_EX, input, 1 bit: the EX stage is held this cycle.
REQ-013 The block SHALL have the port flush_EX, output, 1 bit: a mispredict was found; flush the IF/ID and ID/EX registers.
REQ-014 The block SHALL have the port redirect_pc, output, PC_W bits: the corrected fetch PC, valid while flush_EX=1.
REQ-015 The block SHALL have the port branch_cnt, output, STAT_W bits: the number of branches resolved.
REQ-016 The block SHALL have the port mispredict_cnt, output, STAT_W bits: the number of mispredicts.

Function
REQ-017 The block SHALL keep a branch history table (BHT) of BHT_DEPTH 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 The BHT index SHALL be pc[log2(BHT_DEPTH)-1:0] for both the lookup and the update.
REQ-019 The lookup SHALL be combinational with zero latency: predict_F = MSB of the counter selected by pc_F.
REQ-020 A resolve event SHALL be defined as branch_EX=1, stall_EX=0, and no suppression under REQ-025.
REQ-021 On a resolve event, the block SHALL set mispredict = (prediction_EX != taken_EX).
REQ-022 flush_EX SHALL equal mispredict on a resolve event, combinationally in the same cycle, and SHALL be 0 otherwise.
REQ-023 redirect_pc SHALL be pcBranch_EX when taken_EX=1 and pcPlus2_EX when taken_EX=0; it SHALL be 0 when flush_EX=0.
REQ-024 On each clock edge with a resolve event, the block SHALL move the indexed counter one step toward taken_EX (+1 if taken, -1 if not), saturating at 11 and 00.
REQ-025 A registered flag flush_q SHALL be set to flush_EX each unstalled cycle; while flush_q=1, resolve events SHALL be suppressed, so no counter update, statistic or flush results from the bubble cycle following a flush.
REQ-026 While stall_EX=1, the block SHALL change no state (BHT, counters, flush_q), and flush_EX SHALL be 0.
REQ-027 When a lookup and an update address the same index in the same cycle, predict_F SHALL return the pre-update counter value; no bypass is provided.
REQ-028 branch_cnt SHALL increment by 1 on each resolve event.
REQ-029 mispredict_cnt SHALL increment by 1 on each resolve event with mispredict=1.
REQ-030 Both statistics counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-031 Arithmetic SHALL use unsigned PC_W-bit values; the redirect address SHALL NOT be modified by any wrap or overflow handling.

Reset
REQ-032 While reset=0, every BHT entry SHALL be 01, flush_q=0, branch_cnt=0 and mispredict_cnt=0; outputs therefore read predict_F=0, flush_EX=0, redirect_pc=0, branch_cnt=0, mispredict_cnt=0.
REQ-033 Reset asserted mid-operation SHALL discard any update in flight; the first resolve event after release SHALL see an all-01 table.

Structure
REQ-034 The counter state encodings (SNT/WNT/WT/ST), the reset value WNT and the default PC_W SHALL reside in the shared package pipeline_pkg.
REQ-035 The BHT array and its saturating-update logic SHALL be a single sub-module, bht_2bit; the mispredict, redirect, flush_q and statistics logic SHALL stay in the top module.

Verification
REQ-036 The bench SHALL check: after reset, pc_F=0x10 -> predict_F=0.
REQ-037 The bench SHALL check: a branch at pc_EX=0x10 with prediction_EX=0 and taken_EX=1, pcBranch_EX=0x40 -> flush_EX=1 and redirect_pc=0x40 that cycle; next cycle pc_F=0x10 -> predict_F=1 (counter 10); mispredict_cnt=1.
REQ-038 The bench SHALL check: the same branch resolved taken 3 more times -> the counter holds at 11; one not-taken resolution -> 10 and predict_F stays 1.
REQ-039 The bench SHALL check: a mispredict followed immediately by branch_EX=1 in the bubble cycle -> no second flush, and branch_cnt advances by only 1.
REQ-040 The bench SHALL check: stall_EX=1 held 3 cycles with a mispredicting branch present -> flush_EX=0 and no count change; on release, exactly one flush.
REQ-041 The bench SHALL check: reset pulsed low mid-sequence -> all counters return to 0 and pc_F at any trained index -> predict_F=0.
